// File: rtl/mps_seq_pkg.sv
// mps_seq_pkg -- shared definitions for the MPS main-contactor sequencer.
//   state_t      : sequencer state encoding (also the o_mps_fsm code)
//   FC_*         : latched fault codes reported on o_fault_code
//   DI_*         : bit positions inside the 16-bit external DI word
//   drv_of()     : contactor drive pattern {main, slow, discharge} per state
package mps_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DIS_OPEN = 3'd1,
    ST_PRECHG   = 3'd2,
    ST_MAIN_ON  = 3'd3,
    ST_RUN      = 3'd4,
    ST_SHUTDOWN = 3'd5,
    ST_FAULT    = 3'd6
  } state_t;

  localparam logic [3:0] FC_NONE     = 4'd0;
  localparam logic [3:0] FC_EMERG    = 4'd1;
  localparam logic [3:0] FC_ILK      = 4'd2;
  localparam logic [3:0] FC_DIS_TO   = 4'd3;
  localparam logic [3:0] FC_PRE_TO   = 4'd4;
  localparam logic [3:0] FC_MAIN_TO  = 4'd5;
  localparam logic [3:0] FC_RUN_FB   = 4'd6;
  localparam logic [3:0] FC_SHUT_TO  = 4'd7;
  localparam logic [3:0] FC_EXT_ILK  = 4'd8;

  localparam int DI_EMERG   = 0;
  localparam int DI_MAIN_FB = 1;
  localparam int DI_SLOW_FB = 2;
  localparam int DI_DIS_FB  = 3;
  localparam int DI_ILK_LO  = 4;
  localparam int DI_ILK_HI  = 11;
  localparam int DI_SPARE   = 12;
  localparam int DI_EXT_LO  = 13;
  localparam int DI_EXT_HI  = 15;

  // Returns {main, slow, discharge} for the state being entered, so drives
  // change on the same edge as the state register.
  function automatic logic [2:0] drv_of(input state_t s);
    logic [2:0] d;
    d = 3'b000;
    case (s)
      ST_DIS_OPEN: d = 3'b001;
      ST_PRECHG:   d = 3'b011;
      ST_MAIN_ON:  d = 3'b111;
      ST_RUN:      d = 3'b101;
      ST_SHUTDOWN: d = 3'b001;
      default:     d = 3'b000;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mps_mc_sequencer_if.sv
// mps_mc_sequencer_if -- command/status bundle of the contactor sequencer.
//   Commands (master -> slave): i_start, i_stop, i_fault_clr, each a
//   single-cycle pulse sampled on the rising clock edge; there is no
//   backpressure, a pulse is acted on or ignored in the cycle it is seen.
//   Status (slave -> master): contactor drives, state code, fault, ready,
//   all registered in the sequencer.
interface mps_mc_sequencer_if;
  logic       i_start;
  logic       i_stop;
  logic       i_fault_clr;
  logic       o_main_mc;
  logic       o_slow_charge_mc;
  logic       o_discharge_mc;
  logic [2:0] o_mps_fsm;
  logic       o_fault;
  logic [3:0] o_fault_code;
  logic       o_ready;

  modport master (
    output i_start, i_stop, i_fault_clr,
    input  o_main_mc, o_slow_charge_mc, o_discharge_mc,
    input  o_mps_fsm, o_fault, o_fault_code, o_ready
  );

  modport slave (
    input  i_start, i_stop, i_fault_clr,
    output o_main_mc, o_slow_charge_mc, o_discharge_mc,
    output o_mps_fsm, o_fault, o_fault_code, o_ready
  );
endinterface

// File: rtl/mps_di_debounce.sv
// mps_di_debounce -- per-bit debouncer for already-synchronized inputs.
//   i_clk, i_rst (async, active-low), i_din[P_WIDTH] synchronized samples,
//   o_dout[P_WIDTH] debounced values.
// A bit's output changes only after P_DEB_LEN consecutive samples that all
// differ from the current output; any agreeing sample restarts the count.
module mps_di_debounce #(
  parameter int P_WIDTH   = 16,
  parameter int P_DEB_LEN = 2000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [P_WIDTH-1:0] i_din,
  output logic [P_WIDTH-1:0] o_dout
);

  localparam int LP_CW = (P_DEB_LEN > 1) ? $clog2(P_DEB_LEN) : 1;
  localparam logic [LP_CW-1:0] LP_LAST = LP_CW'(P_DEB_LEN - 1);

  logic [P_WIDTH-1:0] r_dout;
  logic [LP_CW-1:0]   r_cnt [P_WIDTH];

  for (genvar g = 0; g < P_WIDTH; g++) begin : g_bit
    always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
        r_cnt[g]  <= '0;
        r_dout[g] <= 1'b0;
      end else if (i_din[g] == r_dout[g]) begin
        r_cnt[g] <= '0;
      end else if (r_cnt[g] == LP_LAST) begin
        r_cnt[g]  <= '0;
        r_dout[g] <= i_din[g];
      end else begin
        r_cnt[g] <= r_cnt[g] + 1'b1;
      end
    end
  end

  assign o_dout = r_dout;

endmodule

// File: rtl/mps_mc_sequencer.sv
// mps_mc_sequencer -- main / slow-charge / discharge contactor sequencer.
//   i_clk, i_rst   : clock, asynchronous active-low reset
//   i_ext_di[15:0] : raw DI ([0] emergency, [1..3] main/slow/discharge fb,
//                    [11:4] interlocks, [12] spare, [15:13] ext interlocks)
//   bus (slave)    : start/stop/fault_clr pulses in; drives, state code,
//                    fault flag/code and ready out (all registered)
// Optional build macro MPS_SEQ_EXT_ILK_EN: when defined, debounced DI[15:13]
// become fault sources with code 8; otherwise those bits are ignored.
module mps_mc_sequencer
  import mps_seq_pkg::*;
#(
  parameter int P_DEB_LEN     = 2000,
  parameter int P_FB_TIMEOUT  = 200000,
  parameter int P_CHARGE_TIME = 200000000
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [15:0]         i_ext_di,
  mps_mc_sequencer_if.slave   bus
);

  localparam logic [31:0] LP_FB_LAST  = 32'(P_FB_TIMEOUT - 1);
  localparam logic [31:0] LP_CHG_LAST = 32'(P_CHARGE_TIME - 1);

  // ---------------- DI conditioning ----------------
  logic [15:0] r_sync1, r_sync2;
  logic [15:0] w_dbn;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_ext_di;
      r_sync2 <= r_sync1;
    end
  end

  mps_di_debounce #(
    .P_WIDTH   (16),
    .P_DEB_LEN (P_DEB_LEN)
  ) u_deb (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_din  (r_sync2),
    .o_dout (w_dbn)
  );

  logic w_fb_main, w_fb_slow, w_fb_dis;
  assign w_fb_main = w_dbn[DI_MAIN_FB];
  assign w_fb_slow = w_dbn[DI_SLOW_FB];
  assign w_fb_dis  = w_dbn[DI_DIS_FB];

  // Highest-priority active fault source, FC_NONE when healthy.
  logic [3:0] w_src_code;
  always_comb begin
    w_src_code = FC_NONE;
    if (w_dbn[DI_EMERG])                      w_src_code = FC_EMERG;
    else if (|w_dbn[DI_ILK_HI:DI_ILK_LO])     w_src_code = FC_ILK;
`ifdef MPS_SEQ_EXT_ILK_EN
    else if (|w_dbn[DI_EXT_HI:DI_EXT_LO])     w_src_code = FC_EXT_ILK;
`endif
  end

  // Spare bit (and ext bits when the feature is off) are deliberately unused.
  logic w_unused;
  assign w_unused = ^{w_dbn[DI_SPARE], w_dbn[DI_EXT_HI:DI_EXT_LO]};

  // ---------------- sequencer FSM ----------------
  state_t      r_state;
  logic [31:0] r_timer;
  logic        r_chg_seen;   // slow-charge feedback seen; timer now times the hold
  logic [3:0]  r_code;
  logic        r_main, r_slow, r_dis, r_fault, r_ready;

  state_t     w_nxt;
  logic [3:0] w_nxt_code;
  logic       w_tclr, w_chg_set, w_chg_clr;
  logic       w_to;

  assign w_to = (r_timer >= LP_FB_LAST);

  always_comb begin
    w_nxt      = r_state;
    w_nxt_code = r_code;
    w_tclr     = 1'b0;
    w_chg_set  = 1'b0;
    w_chg_clr  = 1'b0;
    if (r_state == ST_FAULT) begin
      if (bus.i_fault_clr && (w_src_code == FC_NONE)) begin
        w_nxt      = ST_IDLE;
        w_nxt_code = FC_NONE;
      end
    end else if (w_src_code != FC_NONE) begin
      w_nxt      = ST_FAULT;
      w_nxt_code = w_src_code;
    end else if (bus.i_stop && (r_state inside {ST_DIS_OPEN, ST_PRECHG, ST_MAIN_ON, ST_RUN})) begin
      w_nxt = ST_SHUTDOWN;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // start together with stop is treated as no request
          if (bus.i_start && !bus.i_stop) w_nxt = ST_DIS_OPEN;
        end
        ST_DIS_OPEN: begin
          if (w_fb_dis)  w_nxt = ST_PRECHG;
          else if (w_to) begin w_nxt = ST_FAULT; w_nxt_code = FC_DIS_TO; end
        end
        ST_PRECHG: begin
          if (!r_chg_seen) begin
            if (w_fb_slow) begin
              w_chg_set = 1'b1;
              w_tclr    = 1'b1;
            end else if (w_to) begin
              w_nxt = ST_FAULT; w_nxt_code = FC_PRE_TO;
            end
          end else if (!w_fb_slow) begin
            // feedback dropped during the hold: wait for it again, re-timed
            w_chg_clr = 1'b1;
            w_tclr    = 1'b1;
          end else if (r_timer >= LP_CHG_LAST) begin
            w_nxt = ST_MAIN_ON;
          end
        end
        ST_MAIN_ON: begin
          if (w_fb_main) w_nxt = ST_RUN;
          else if (w_to) begin w_nxt = ST_FAULT; w_nxt_code = FC_MAIN_TO; end
        end
        ST_RUN: begin
          // timer measures how long the feedback mismatch has persisted
          if (!w_fb_main || !w_fb_dis || w_fb_slow) begin
            if (w_to) begin w_nxt = ST_FAULT; w_nxt_code = FC_RUN_FB; end
          end else begin
            w_tclr = 1'b1;
          end
        end
        ST_SHUTDOWN: begin
          if (!w_fb_main && !w_fb_slow) w_nxt = ST_IDLE;
          else if (w_to) begin w_nxt = ST_FAULT; w_nxt_code = FC_SHUT_TO; end
        end
        default: w_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= ST_IDLE;
      r_timer    <= '0;
      r_chg_seen <= 1'b0;
      r_code     <= FC_NONE;
      r_main     <= 1'b0;
      r_slow     <= 1'b0;
      r_dis      <= 1'b0;
      r_fault    <= 1'b0;
      r_ready    <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_code  <= w_nxt_code;
      r_timer <= ((w_nxt != r_state) || w_tclr) ? '0 : r_timer + 32'd1;
      if (w_nxt != r_state)  r_chg_seen <= 1'b0;
      else if (w_chg_set)    r_chg_seen <= 1'b1;
      else if (w_chg_clr)    r_chg_seen <= 1'b0;
      {r_main, r_slow, r_dis} <= drv_of(w_nxt);
      r_fault <= (w_nxt == ST_FAULT);
      r_ready <= (w_nxt == ST_RUN);
    end
  end

  assign bus.o_main_mc        = r_main;
  assign bus.o_slow_charge_mc = r_slow;
  assign bus.o_discharge_mc   = r_dis;
  assign bus.o_mps_fsm        = r_state;
  assign bus.o_fault          = r_fault;
  assign bus.o_fault_code     = r_code;
  assign bus.o_ready          = r_ready;

endmodule

// File: tb/tb_mps_mc_sequencer.sv
module tb_mps_mc_sequencer;

  logic        clk;
  logic        rst_n;
  logic [15:0] di_man;
  logic        fb_auto;
  logic [9:0]  dly_main, dly_slow, dly_dis;
  logic [15:0] w_di;

  int n_total = 0;
  int n_bad   = 0;

  logic [2:0] exp_q[$];
  logic [2:0] got_q[$];
  logic       rec_en = 1'b0;
  logic [2:0] last_st = 3'd0;
  int         dwell = 0;
  logic       saw_shut = 1'b0;

  mps_mc_sequencer_if bus();

  mps_mc_sequencer #(
    .P_DEB_LEN     (4),
    .P_FB_TIMEOUT  (100),
    .P_CHARGE_TIME (50)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst_n),
    .i_ext_di (w_di),
    .bus      (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- contactor feedback model (10-cycle lag) ----------------
  always @(negedge clk) begin
    dly_main = {dly_main[8:0], bus.o_main_mc};
    dly_slow = {dly_slow[8:0], bus.o_slow_charge_mc};
    dly_dis  = {dly_dis[8:0],  bus.o_discharge_mc};
  end

  assign w_di = fb_auto ? {di_man[15:4], dly_dis[9], dly_slow[9], dly_main[9], di_man[0]}
                        : di_man;

  // ---------------- state monitor ----------------
  always @(negedge clk) begin
    if (rec_en && (bus.o_mps_fsm != last_st)) got_q.push_back(bus.o_mps_fsm);
    last_st = bus.o_mps_fsm;
    if (bus.o_mps_fsm == 3'd2 && w_di[2]) dwell++;
    if (bus.o_mps_fsm == 3'd5) saw_shut = 1'b1;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // 0 = start, 1 = stop, 2 = fault_clr, 3 = start+stop
  task automatic pulse_cmd(input int which);
    bus.i_start     = (which == 0) || (which == 3);
    bus.i_stop      = (which == 1) || (which == 3);
    bus.i_fault_clr = (which == 2);
    @(negedge clk);
    bus.i_start     = 1'b0;
    bus.i_stop      = 1'b0;
    bus.i_fault_clr = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int n;
    n = 0;
    while (bus.o_mps_fsm != s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(bus.o_mps_fsm), 32'(s));
  endtask

  task automatic check_drives(input string tag, input logic [2:0] exp);
    check(tag, 32'({bus.o_main_mc, bus.o_slow_charge_mc, bus.o_discharge_mc}), 32'(exp));
  endtask

  task automatic go_run(input string tag);
    fb_auto = 1'b1;
    pulse_cmd(0);
    wait_state(3'd4, 3000, tag);
    cycles(30);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst_n = 1'b0;
    di_man = '0;
    fb_auto = 1'b0;
    dly_main = '0; dly_slow = '0; dly_dis = '0;
    bus.i_start = 1'b0; bus.i_stop = 1'b0; bus.i_fault_clr = 1'b0;
    cycles(3);
    // reset values
    check("rst_state", 32'(bus.o_mps_fsm), 0);
    check_drives("rst_drv", 3'b000);
    check("rst_fault", 32'(bus.o_fault), 0);
    check("rst_code", 32'(bus.o_fault_code), 0);
    check("rst_ready", 32'(bus.o_ready), 0);
    rst_n = 1'b1;
    cycles(5);

    // start + stop together in IDLE: no move
    pulse_cmd(3);
    cycles(3);
    check("idle_start_stop", 32'(bus.o_mps_fsm), 0);

    // full power-up sequence
    exp_q = '{3'd1, 3'd2, 3'd3, 3'd4};
    got_q.delete();
    dwell = 0;
    rec_en = 1'b1;
    go_run("seq_reach_run");
    rec_en = 1'b0;
    check("seq_len", 32'(got_q.size()), 4);
    while (exp_q.size() > 0 && got_q.size() > 0)
      check("seq_order", 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    check("prechg_dwell", 32'((dwell >= 50) && (dwell <= 60)), 1);
    check("run_ready", 32'(bus.o_ready), 1);
    check_drives("run_drv", 3'b101);
    cycles(150);
    check("run_stable", 32'(bus.o_mps_fsm), 4);

    // stop -> shutdown -> idle
    pulse_cmd(1);
    check("stop_shutdown", 32'(bus.o_mps_fsm), 5);
    check_drives("shut_drv", 3'b001);
    wait_state(3'd0, 300, "shut_to_idle");
    check_drives("idle_drv", 3'b000);
    cycles(40);

    // discharge feedback never arrives
    fb_auto = 1'b0;
    di_man = '0;
    pulse_cmd(0);
    n = 0;
    while (bus.o_mps_fsm == 3'd1 && n < 300) begin
      n++;
      @(negedge clk);
    end
    check("dis_to_cycles", 32'(n), 100);
    check("dis_to_state", 32'(bus.o_mps_fsm), 6);
    check("dis_to_code", 32'(bus.o_fault_code), 3);
    check("dis_to_fault", 32'(bus.o_fault), 1);
    check_drives("dis_to_drv", 3'b000);
    pulse_cmd(2);
    check("clr_state", 32'(bus.o_mps_fsm), 0);
    check("clr_code", 32'(bus.o_fault_code), 0);
    check("clr_fault", 32'(bus.o_fault), 0);
    cycles(20);

    // emergency glitch then real emergency in RUN
    go_run("emg_reach_run");
    di_man[0] = 1'b1; cycles(3); di_man[0] = 1'b0;
    cycles(20);
    check("emg_glitch", 32'(bus.o_mps_fsm), 4);
    di_man[0] = 1'b1; cycles(5); di_man[0] = 1'b0;
    wait_state(3'd6, 30, "emg_fault");
    check("emg_code", 32'(bus.o_fault_code), 1);
    check_drives("emg_drv", 3'b000);
    cycles(20);
    pulse_cmd(2);
    check("emg_clr", 32'(bus.o_mps_fsm), 0);
    cycles(40);

    // interlock and stop on the same edge: fault wins
    go_run("ilk_reach_run");
    saw_shut = 1'b0;
    di_man[5] = 1'b1;
    cycles(6);
    pulse_cmd(1);
    cycles(2);
    check("ilk_state", 32'(bus.o_mps_fsm), 6);
    check("ilk_code", 32'(bus.o_fault_code), 2);
    check("ilk_no_shut", 32'(saw_shut), 0);
    di_man[5] = 1'b0;
    cycles(20);
    pulse_cmd(2);
    cycles(40);

    // asynchronous reset during the precharge hold
    fb_auto = 1'b1;
    pulse_cmd(0);
    wait_state(3'd2, 100, "rst_reach_prechg");
    cycles(25);
    check("rst_in_prechg", 32'(bus.o_mps_fsm), 2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_state", 32'(bus.o_mps_fsm), 0);
    check_drives("arst_drv", 3'b000);
    cycles(3);
    rst_n = 1'b1;
    cycles(3);
    check("arst_idle", 32'(bus.o_mps_fsm), 0);
    cycles(40);

    // external interlock bit 14 in RUN
    go_run("ext_reach_run");
    di_man[14] = 1'b1;
    cycles(30);
`ifdef MPS_SEQ_EXT_ILK_EN
    check("ext_state", 32'(bus.o_mps_fsm), 6);
    check("ext_code", 32'(bus.o_fault_code), 8);
`else
    check("ext_state", 32'(bus.o_mps_fsm), 4);
    check("ext_code", 32'(bus.o_fault_code), 0);
`endif
    di_man[14] = 1'b0;
    cycles(10);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // hard time bound
  initial begin
    #2000000;
    $display("FAIL global_timeout: got=1 want=0");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mps_mc_sequencer.md
MPS_MC_SEQUENCER -- requirements
Module: mps_mc_sequencer

Interface
REQ-001 SHALL have parameter P_DEB_LEN, default 2000: consecutive stable samples (10 us at 200 MHz) before a debounced DI bit changes.
REQ-002 SHALL have parameter P_FB_TIMEOUT, default 200000: cycles allowed for contactor feedback to follow command.
REQ-003 SHALL have parameter P_CHARGE_TIME, default 200000000: precharge hold cycles after slow-charge feedback.
REQ-004 SHALL have port i_clk  input  1  single system clock.
REQ-005 SHALL have port i_rst  input  1  reset; asynchronous and active-low.
REQ-006 SHALL have port i_ext_di  input  16  raw DI; [0] emergency, [1] main MC fb, [2] slow-charge MC fb, [3] discharge MC fb, [11:4] interlocks, [12] spare, [15:13] ext 1-3; 1 = active/closed.
REQ-007 SHALL have ports i_start, i_stop, i_fault_clr  input  1 each  single-cycle command pulses.
REQ-008 SHALL have ports o_main_mc, o_slow_charge_mc, o_discharge_mc  output  1 each  registered contactor drives; 1 = energized.
REQ-009 SHALL have port o_mps_fsm  output  3  current state code.
REQ-010 SHALL have ports o_fault  output  1  and o_fault_code  output  4  latched fault.
REQ-011 SHALL have port o_ready  output  1  high only in RUN.

Function
REQ-012 SHALL pass each i_ext_di bit through a 2-flop synchronizer, then a debouncer; all decisions use debounced values only.
REQ-013 SHALL implement states IDLE=0, DIS_OPEN=1, PRECHG=2, MAIN_ON=3, RUN=4, SHUTDOWN=5, FAULT=6.
REQ-014 SHALL use one 32-bit timer, cleared on every state entry, incrementing each cycle otherwise.
REQ-015 IDLE: outputs all 0; i_start with no active fault source -> DIS_OPEN; i_start outside IDLE ignored.
REQ-016 DIS_OPEN: discharge=1; fb[3]=1 -> PRECHG; timer reaching P_FB_TIMEOUT -> FAULT code 3.
REQ-017 PRECHG: discharge=1, slow=1; fb[2] must be 1 before P_FB_TIMEOUT (else code 4); after fb[2]=1 held P_CHARGE_TIME cycles -> MAIN_ON.
REQ-018 MAIN_ON: discharge=1, slow=1, main=1; fb[1]=1 -> RUN; timeout -> code 5.
REQ-019 RUN: discharge=1, main=1, slow=0; any mismatch fb[1]!=1, fb[3]!=1 or fb[2]!=0 persisting P_FB_TIMEOUT cycles -> code 6.
REQ-020 i_stop in states 1-4 -> SHUTDOWN: main=0, slow=0, discharge=1; fb[1]=0 and fb[2]=0 -> IDLE (discharge drops to 0); timeout -> code 7.
REQ-021 From any state except FAULT: debounced emergency -> code 1; any interlock [11:4] -> code 2; evaluated before all other transitions.
REQ-022 FAULT: all drives 0 in the same cycle the state is entered; o_fault=1, code latched (first fault only).
REQ-023 FAULT exits to IDLE on i_fault_clr only when no fault source is active; o_fault and code clear to 0.
REQ-024 Simultaneous events: fault beats i_stop beats i_start beats feedback progress; i_start+i_stop in IDLE -> stay IDLE.
REQ-025 State-to-output latency: drives and o_mps_fsm update on the clock edge that enters the state.

Reset
REQ-026 Reset asserted (any time, mid-sequence included) SHALL force IDLE, all drives 0, o_fault=0, o_fault_code=0, o_ready=0, timer 0, debounced DI 0, synchronizers 0.
REQ-027 After deassertion SHALL require P_DEB_LEN stable samples before any DI is seen active.

Configuration
REQ-028 With MPS_SEQ_EXT_ILK_EN defined, debounced bits [15:13] SHALL be fault sources with code 8 (priority below code 2).
REQ-029 Without MPS_SEQ_EXT_ILK_EN, bits [15:13] SHALL be ignored entirely and code 8 never occurs.

Structure
REQ-030 Package mps_seq_pkg SHALL hold the state enum, fault-code constants (1-8) and DI bit-index constants.
REQ-031 Debouncer SHALL be sub-module mps_di_debounce (parameter width, P_DEB_LEN; per-bit counter), instantiated once for 16 bits.

Verification (P_DEB_LEN=4, P_FB_TIMEOUT=100, P_CHARGE_TIME=50)
REQ-032 Start, feedbacks follow each drive after 10 cycles -> states 1,2,3,4 in order; o_ready=1; precharge dwell >=50 cycles after fb[2].
REQ-033 Start, fb[3] never rises -> FAULT at timer 100, code 3, drives 0; i_fault_clr -> IDLE, code 0.
REQ-034 In RUN, di[0] pulses 3 cycles -> no fault; held 5 cycles -> FAULT code 1, drives 0 same cycle.
REQ-035 In RUN, i_stop and di[5]=1 debounced same cycle -> FAULT code 2, not SHUTDOWN.
REQ-036 In PRECHG, assert i_rst mid-hold -> all outputs 0 asynchronously, IDLE after release.
REQ-037 di[14]=1 in RUN -> code 8 with MPS_SEQ_EXT_ILK_EN, no effect without.
